// File: rtl/minirv_pipe_cpu.sv
// minirv_pipe_cpu: 5-stage RV32I-subset pipeline (IF/ID/EX/MEM/WB) with forwarding, interlocks, flush and bus wait states; MINIRV_PIPE_TRACE_EN adds WB trace ports
module minirv_pipe_cpu #(
    parameter int          IADDR_W  = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          FWD_EN   = 1'b1
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    output logic [IADDR_W-1:0] inst_addr,
    input  logic [31:0]        inst,
    output logic [31:0]        Bus_addr,
    input  logic [31:0]        Bus_rdata,
    output logic               Bus_wen,
    output logic               Bus_ren,
    output logic [31:0]        Bus_wdata,
    input  logic               Bus_ready
`ifdef MINIRV_PIPE_TRACE_EN
    ,
    output logic               debug_wb_have_inst,
    output logic [31:0]        debug_wb_pc,
    output logic               debug_wb_ena,
    output logic [4:0]         debug_wb_reg,
    output logic [31:0]        debug_wb_value
`endif
);
    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ir;
    } fd_t;
    typedef struct packed {
        logic        v;
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  aop;
        logic        we, ld, st, br, jal, jalr, bimm, apc, azero;
    } de_t;
    typedef struct packed {
        logic        v;
`ifdef MINIRV_PIPE_TRACE_EN
        logic [31:0] pc;
`endif
        logic [31:0] res, wdata;
        logic [4:0]  rd;
        logic        we, ld, st;
    } em_t;
    typedef struct packed {
        logic        v;
`ifdef MINIRV_PIPE_TRACE_EN
        logic [31:0] pc;
`endif
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
    } mw_t;

    logic [31:0] pc_q, pc_d;
    fd_t         fd_q, fd_d;
    de_t         de_q, de_d, id;
    em_t         em_q, em_d;
    mw_t         mw_q, mw_d;
    logic [31:0] rf_q [32];
    logic [31:0] ir, rd1, rd2, fa, fb, opa, opb, sra, alu, tgt, ex_res;
    logic [6:0]  op;
    logic [2:0]  f3, bf3;
    logic [4:0]  sh;
    logic        is_r, is_i, wb_we, em_fw, mw_fw, cond, taken, freeze, stall;

    function automatic logic hit(input logic v, input logic we, input logic [4:0] rd,
                                 input logic [4:0] r1, input logic [4:0] r2);
        return v & we & (rd != 5'd0) & (rd == r1 | rd == r2);
    endfunction

    assign ir    = fd_q.ir;
    assign op    = ir[6:0];
    assign f3    = ir[14:12];
    assign is_r  = op == 7'h33;
    assign is_i  = op == 7'h13;
    assign wb_we = mw_q.v & mw_q.we & (mw_q.rd != 5'd0) & ~freeze;
    assign rd1   = ir[19:15] == 5'd0 ? 32'd0 : wb_we && mw_q.rd == ir[19:15] ? mw_q.res : rf_q[ir[19:15]];
    assign rd2   = ir[24:20] == 5'd0 ? 32'd0 : wb_we && mw_q.rd == ir[24:20] ? mw_q.res : rf_q[ir[24:20]];

    always_comb begin
        id       = '0;
        id.v     = fd_q.v;
        id.pc    = fd_q.pc;
        id.a     = rd1;
        id.b     = rd2;
        id.rs1   = ir[19:15];
        id.rs2   = ir[24:20];
        id.rd    = ir[11:7];
        id.ld    = op == 7'h03;
        id.st    = op == 7'h23;
        id.br    = op == 7'h63;
        id.jal   = op == 7'h6f;
        id.jalr  = op == 7'h67;
        id.apc   = op == 7'h17;
        id.azero = op == 7'h37;
        id.we    = is_r | is_i | id.ld | id.jal | id.jalr | id.apc | id.azero;
        id.bimm  = ~is_r & ~id.br;
        id.aop   = {is_r ? ir[30] : is_i & (f3 == 3'b101) & ir[30], (is_r | is_i | id.br) ? f3 : 3'b000};
        id.imm   = id.st ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
                   id.br ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
                   (id.apc | id.azero) ? {ir[31:12], 12'd0} :
                   id.jal ? {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0} :
                   {{20{ir[31]}}, ir[31:20]};
    end

    assign em_fw  = FWD_EN & em_q.v & em_q.we & ~em_q.ld & (em_q.rd != 5'd0);
    assign mw_fw  = FWD_EN & mw_q.v & mw_q.we & (mw_q.rd != 5'd0);
    assign fa     = em_fw && em_q.rd == de_q.rs1 ? em_q.res : mw_fw && mw_q.rd == de_q.rs1 ? mw_q.res : de_q.a;
    assign fb     = em_fw && em_q.rd == de_q.rs2 ? em_q.res : mw_fw && mw_q.rd == de_q.rs2 ? mw_q.res : de_q.b;
    assign opa    = de_q.apc ? de_q.pc : de_q.azero ? 32'd0 : fa;
    assign opb    = de_q.bimm ? de_q.imm : fb;
    assign sh     = opb[4:0];
    assign sra    = $signed(opa) >>> sh;
    assign alu    = de_q.aop == 4'b1000 ? opa - opb :
                    de_q.aop[2:0] == 3'd1 ? opa << sh :
                    de_q.aop[2:0] == 3'd2 ? {31'd0, $signed(opa) < $signed(opb)} :
                    de_q.aop[2:0] == 3'd3 ? {31'd0, opa < opb} :
                    de_q.aop[2:0] == 3'd4 ? opa ^ opb :
                    de_q.aop[2:0] == 3'd5 ? (de_q.aop[3] ? sra : opa >> sh) :
                    de_q.aop[2:0] == 3'd6 ? opa | opb :
                    de_q.aop[2:0] == 3'd7 ? opa & opb : opa + opb;
    assign bf3    = de_q.aop[2:0];
    assign cond   = (bf3[2] ? (bf3[1] ? fa < fb : $signed(fa) < $signed(fb)) : fa == fb) ^ bf3[0];
    assign taken  = de_q.v & (de_q.br & cond | de_q.jal | de_q.jalr);
    assign tgt    = de_q.jalr ? (fa + de_q.imm) & ~32'd1 : de_q.pc + de_q.imm;
    assign ex_res = (de_q.jal | de_q.jalr) ? de_q.pc + 32'd4 : alu;
    assign freeze = em_q.v & (em_q.ld | em_q.st) & ~Bus_ready;
    assign stall  = fd_q.v & ~taken & (FWD_EN ?
                    hit(de_q.v, de_q.we, de_q.rd, ir[19:15], ir[24:20]) & de_q.ld :
                    hit(de_q.v, de_q.we, de_q.rd, ir[19:15], ir[24:20]) |
                    hit(em_q.v, em_q.we, em_q.rd, ir[19:15], ir[24:20]) |
                    hit(mw_q.v, mw_q.we, mw_q.rd, ir[19:15], ir[24:20]));

    always_comb begin
        pc_d = pc_q;
        fd_d = fd_q;
        de_d = de_q;
        em_d = em_q;
        mw_d = mw_q;
        if (!freeze) begin
            pc_d     = taken ? tgt : stall ? pc_q : pc_q + 32'd4;
            fd_d     = taken ? fd_t'('0) : stall ? fd_q : {1'b1, pc_q, inst};
            de_d     = taken | stall ? de_t'('0) : id;
            em_d.v     = de_q.v;
            em_d.res   = ex_res;
            em_d.wdata = fb;
            em_d.rd    = de_q.rd;
            em_d.we    = de_q.we;
            em_d.ld    = de_q.ld;
            em_d.st    = de_q.st;
            mw_d.v     = em_q.v;
            mw_d.res   = em_q.ld ? Bus_rdata : em_q.res;
            mw_d.rd    = em_q.rd;
            mw_d.we    = em_q.we;
`ifdef MINIRV_PIPE_TRACE_EN
            em_d.pc    = de_q.pc;
            mw_d.pc    = em_q.pc;
`endif
        end
    end

`ifdef MINIRV_PIPE_TRACE_EN
    logic [70:0] tr_q, tr_d;
    always_comb tr_d = {mw_q.v & ~freeze, mw_q.pc, wb_we, mw_q.rd, mw_q.res};
    assign {debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value} = tr_q;
    always_ff @(posedge cpu_clk) tr_q <= cpu_rst ? '0 : tr_d;
`endif

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            pc_q <= RESET_PC;
            fd_q <= '0;
            de_q <= '0;
            em_q <= '0;
            mw_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            fd_q <= fd_d;
            de_q <= de_d;
            em_q <= em_d;
            mw_q <= mw_d;
            if (wb_we) rf_q[mw_q.rd] <= mw_q.res;
        end
    end

    assign inst_addr = pc_q[IADDR_W+1:2];
    assign Bus_addr  = em_q.res;
    assign Bus_wdata = em_q.wdata;
    assign Bus_wen   = em_q.v & em_q.st;
    assign Bus_ren   = em_q.v & em_q.ld;
endmodule
